// File: rtl/pedestrian_request_controller_pkg.sv
// Shared definitions for the pedestrian request controller: signal codes,
// FSM state encoding and default timing constants.
package pedestrian_request_controller_pkg;

   localparam int unsigned DEFAULT_TICKS_PER_SEC = 5000;
   localparam int unsigned DEBOUNCE_CNT_W        = 4;

   typedef logic [1:0] ped_code_t;

   localparam ped_code_t PED_HAND  = 2'b00;
   localparam ped_code_t PED_FLASH = 2'b01;
   localparam ped_code_t PED_WALK  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQUEST = 3'd1,
      ST_WALK    = 3'd2,
      ST_FLASH   = 3'd3,
      ST_DONE    = 3'd4
   } ped_state_t;

endpackage

// File: rtl/pedestrian_request_controller_second_timer.sv
// second_timer: prescaler plus seconds counter; load clears both and captures
// max(loadTime,1) as the interval; counting holds once the interval expires.
module second_timer
   import pedestrian_request_controller_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
   parameter int unsigned TIME_W        = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [TIME_W-1:0] loadTime,
   output logic              expired_c
);

   localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

   logic [PRE_W-1:0]  prescale;
   logic [TIME_W-1:0] seconds;
   logic [TIME_W-1:0] limit;

   assign expired_c = (prescale == PRE_LAST) && (seconds == limit - TIME_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale <= '0;
         seconds  <= '0;
         limit    <= TIME_W'(1);
      end else if (load) begin
         prescale <= '0;
         seconds  <= '0;
         limit    <= (loadTime == '0) ? TIME_W'(1) : loadTime;
      end else if (!expired_c) begin
         if (prescale == PRE_LAST) begin
            prescale <= '0;
            seconds  <= seconds + TIME_W'(1);
         end else begin
            prescale <= prescale + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/pedestrian_request_controller.sv
// Pedestrian crossing request controller with timed WALK / flashing-hand phases.
// Optional macro PED_DEBOUNCE_EN adds a 16-sample debounce after the synchronizer.
module pedestrian_request_controller
   import pedestrian_request_controller_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
   parameter int unsigned TIME_W        = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              button,
   input  logic [TIME_W-1:0] walkTime,
   input  logic [TIME_W-1:0] handTime,
   input  logic              grant,
   output logic              req,
   output logic              done,
   output logic [1:0]        pedControl
);

   ped_state_t        state, nextState;
   logic              btnMeta, btnSync, btnClean, btnPrev, btnRise;
   logic              pending;
   logic              timerLoad, timerExpired;
   logic [TIME_W-1:0] timerTime;
   logic              reqNext, doneNext;
   ped_code_t         pedNext;

   always_ff @(posedge clk) begin
      if (reset) begin
         btnMeta <= 1'b0;
         btnSync <= 1'b0;
      end else begin
         btnMeta <= button;
         btnSync <= btnMeta;
      end
   end

`ifdef PED_DEBOUNCE_EN
   logic [DEBOUNCE_CNT_W-1:0] dbCnt;

   // Accept a new level only after 16 consecutive samples that disagree with the current one
   always_ff @(posedge clk) begin
      if (reset) begin
         btnClean <= 1'b0;
         dbCnt    <= '0;
      end else if (btnSync == btnClean) begin
         dbCnt <= '0;
      end else if (dbCnt == {DEBOUNCE_CNT_W{1'b1}}) begin
         btnClean <= btnSync;
         dbCnt    <= '0;
      end else begin
         dbCnt <= dbCnt + DEBOUNCE_CNT_W'(1);
      end
   end
`else
   assign btnClean = btnSync;
`endif

   assign btnRise = btnClean & ~btnPrev;

   // Clearing on IDLE->REQUEST wins: an edge then is the same request
   always_ff @(posedge clk) begin
      if (reset) begin
         btnPrev <= 1'b0;
         pending <= 1'b0;
      end else begin
         btnPrev <= btnClean;
         if (state == ST_IDLE && pending)
            pending <= 1'b0;
         else if (btnRise && state != ST_REQUEST)
            pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         req        <= 1'b0;
         done       <= 1'b0;
         pedControl <= PED_HAND;
      end else begin
         state      <= nextState;
         req        <= reqNext;
         done       <= doneNext;
         pedControl <= pedNext;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:    if (pending) nextState = ST_REQUEST;
         ST_REQUEST: if (grant) nextState = ST_WALK;
         ST_WALK:    if (!grant) nextState = ST_DONE;
                     else if (timerExpired) nextState = ST_FLASH;
         ST_FLASH:   if (!grant || timerExpired) nextState = ST_DONE;
         ST_DONE:    nextState = ST_IDLE;
         default:    nextState = ST_IDLE;
      endcase
      timerLoad = (nextState != state);
      timerTime = (nextState == ST_WALK) ? walkTime : handTime;
   end

   // Outputs are registered from the upcoming state so they align with it
   always_comb begin
      reqNext  = 1'b0;
      doneNext = 1'b0;
      pedNext  = PED_HAND;
      case (nextState)
         ST_REQUEST: reqNext = 1'b1;
         ST_WALK: begin
            reqNext = 1'b1;
            pedNext = PED_WALK;
         end
         ST_FLASH: begin
            reqNext = 1'b1;
            pedNext = PED_FLASH;
         end
         ST_DONE:    doneNext = 1'b1;
         default:    ;
      endcase
   end

   second_timer #(
      .TICKS_PER_SEC(TICKS_PER_SEC),
      .TIME_W       (TIME_W)
   ) uTimer (
      .clk      (clk),
      .reset    (reset),
      .load     (timerLoad),
      .loadTime (timerTime),
      .expired_c(timerExpired)
   );

endmodule

// File: tb/tb_pedestrian_request_controller.sv
// Self-checking bench for pedestrian_request_controller (TICKS_PER_SEC=4).
// Build with PED_DEBOUNCE_EN defined to exercise the debounce path instead.
module tb_pedestrian_request_controller;
   import pedestrian_request_controller_pkg::*;

   logic       clk = 1'b0;
   logic       reset, button, grant;
   logic [5:0] walkTime, handTime;
   logic       req, done;
   logic [1:0] pedControl;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [5:0] walkTime;
      logic [5:0] handTime;
      int         pressAt;
      bit         perturb;
      int         expWalk;
      int         expFlash;
      bit         expReReq;
   } vec_t;

   vec_t vecs[6];

   pedestrian_request_controller #(.TICKS_PER_SEC(4), .TIME_W(6)) dut (
      .clk(clk), .reset(reset), .button(button), .walkTime(walkTime),
      .handTime(handTime), .grant(grant), .req(req), .done(done),
      .pedControl(pedControl)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic startRequest(input string name);
      button = 1'b1;
      tick();
      button = 1'b0;
      tick();
      tick();
      check({name, "_reqEarly"}, int'(req), 0);
      tick();
      check({name, "_reqLatency"}, int'(req), 1);
      check({name, "_pedReq"}, int'(pedControl), int'(PED_HAND));
   endtask

   task automatic waitDone(input string name);
      int g = 0;
      while (!done && g < 600) begin
         tick();
         g++;
      end
      check({name, "_doneReached"}, int'(done), 1);
      tick();
   endtask

   task automatic runCrossing(input int idx, input vec_t v);
      int walkCnt = 0, flashCnt = 0, g = 0;
      string nm = $sformatf("vec%0d", idx);
      walkTime = v.walkTime;
      handTime = v.handTime;
      grant    = 1'b1;
      startRequest(nm);
      tick();
      while (pedControl == PED_WALK && g < 600) begin
         walkCnt++;
         if (v.perturb && walkCnt == 1) walkTime = 6'd9;
         check({nm, "_reqWalk"}, int'(req), 1);
         tick();
         g++;
      end
      while (pedControl == PED_FLASH && g < 1200) begin
         flashCnt++;
         if (v.perturb && flashCnt == 1) handTime = 6'd9;
         button = (flashCnt == v.pressAt);
         tick();
         g++;
      end
      button = 1'b0;
      check({nm, "_walkCycles"}, walkCnt, v.expWalk);
      check({nm, "_flashCycles"}, flashCnt, v.expFlash);
      check({nm, "_donePulse"}, int'(done), 1);
      check({nm, "_doneReq"}, int'(req), 0);
      check({nm, "_donePed"}, int'(pedControl), int'(PED_HAND));
      tick();
      check({nm, "_doneOneCycle"}, int'(done), 0);
      check({nm, "_idleReq"}, int'(req), 0);
      tick();
      check({nm, "_reRequest"}, int'(req), int'(v.expReReq));
      if (v.expReReq) waitDone({nm, "_second"});
   endtask

   initial begin
      bit seen;
      bit seenDone;
      int lat;
      vecs[0] = '{6'd3,  6'd2, -1, 1'b0, 12,  8, 1'b0};
      vecs[1] = '{6'd0,  6'd0, -1, 1'b0,  4,  4, 1'b0};
      vecs[2] = '{6'd1,  6'd2,  2, 1'b0,  4,  8, 1'b1};
      vecs[3] = '{6'd0,  6'd0,  3, 1'b0,  4,  4, 1'b1};
      vecs[4] = '{6'd2,  6'd1, -1, 1'b1,  8,  4, 1'b0};
      vecs[5] = '{6'd63, 6'd1, -1, 1'b0, 252, 4, 1'b0};

      reset = 1'b1; button = 1'b0; grant = 1'b0; walkTime = '0; handTime = '0;
      tick();
      tick();
      check("rst_req", int'(req), 0);
      check("rst_done", int'(done), 0);
      check("rst_ped", int'(pedControl), int'(PED_HAND));
      reset = 1'b0;

`ifdef PED_DEBOUNCE_EN
      grant = 1'b1; walkTime = 6'd1; handTime = 6'd1;
      button = 1'b1;
      repeat (5) tick();
      button = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         tick();
         seen |= req;
      end
      check("db_glitchNoReq", int'(seen), 0);
      button = 1'b1;
      lat = 0;
      while (!req && lat < 40) begin
         tick();
         lat++;
         if (lat == 20) button = 1'b0;
      end
      button = 1'b0;
      check("db_heldReq", int'(req), 1);
      check("db_latencyRange", int'(lat >= 17 && lat <= 25), 1);
      waitDone("db");
`else
      grant = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         tick();
         seen |= req;
      end
      check("idleGrantNoReq", int'(seen), 0);

      for (int i = 0; i < 6; i++) runCrossing(i, vecs[i]);

      // Abort: grant dropped in the fifth WALK cycle
      walkTime = 6'd3; handTime = 6'd2; grant = 1'b1;
      startRequest("abort");
      tick();
      repeat (4) tick();
      check("abort_inWalk", int'(pedControl), int'(PED_WALK));
      grant = 1'b0;
      tick();
      check("abort_done", int'(done), 1);
      check("abort_ped", int'(pedControl), int'(PED_HAND));
      check("abort_req", int'(req), 0);
      tick();
      check("abort_idleDone", int'(done), 0);
      check("abort_idleReq", int'(req), 0);

      // Button press while waiting in REQUEST is not remembered
      grant = 1'b0; walkTime = 6'd0; handTime = 6'd0;
      startRequest("reqIgnore");
      button = 1'b1;
      tick();
      button = 1'b0;
      repeat (4) tick();
      check("reqIgnore_holdReq", int'(req), 1);
      check("reqIgnore_holdPed", int'(pedControl), int'(PED_HAND));
      grant = 1'b1;
      waitDone("reqIgnore");
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen |= req;
      end
      check("reqIgnore_noSecondReq", int'(seen), 0);

      // Reset in the middle of WALK
      walkTime = 6'd3; handTime = 6'd2; grant = 1'b1;
      startRequest("rstWalk");
      repeat (3) tick();
      check("rstWalk_inWalk", int'(pedControl), int'(PED_WALK));
      reset = 1'b1;
      tick();
      check("rstWalk_ped", int'(pedControl), int'(PED_HAND));
      check("rstWalk_req", int'(req), 0);
      check("rstWalk_done", int'(done), 0);
      reset = 1'b0;
      seen = 1'b0; seenDone = 1'b0;
      repeat (30) begin
         tick();
         seen |= req;
         seenDone |= done;
      end
      check("rstWalk_noDone", int'(seenDone), 0);
      check("rstWalk_noReq", int'(seen), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
